spi_exe_frame_rx: RTL and testbench

SPI slave front end for the execution unit.
- Deserialises one command frame per chip-select window (8-bit opcode, M-bit argA, M-bit argB).
- Presents the fields, registered, to the exe stage with a one-cycle valid strobe.
- Shifts the exe stage's latest M-bit result back out on MISO during the next frame.
- All logic runs in the i_clk domain; SPI pins are oversampled (mode 0: sample on SCLK rise, shift on SCLK fall).

---
 rtl/spi_exe_frame_rx.sv | 206 ++++++++++++++++++++
 tb/tb_spi_exe_frame_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_exe_frame_rx.sv
// SPI mode-0 slave front end for the exe stage: receives {opcode, argA, argB} per CS window and
// shifts the most recent exe result back out on MISO during the following frame.
module spi_exe_frame_rx #(
    parameter int unsigned M   = 4,
    parameter int unsigned OPW = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_sclk,
    input  logic           i_cs_n,
    input  logic           i_mosi,
    output logic           o_miso,
    output logic [OPW-1:0] o_op,
    output logic [M-1:0]   o_argA,
    output logic [M-1:0]   o_argB,
    output logic           o_valid,
    input  logic [M-1:0]   i_result,
    input  logic           i_result_valid,
    output logic           o_frame_err
);

    localparam int unsigned F  = OPW + 2 * M;
    localparam int unsigned CW = $clog2(F + 1);
    localparam logic [CW-1:0] FCNT = CW'(F);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StWaitCs
    } state_e;

    // Synchronisers
    logic sclk_s1;
    logic sclk_s2;
    logic sclk_h;
    logic cs_s1;
    logic cs_s2;
    logic cs_h;
    logic mosi_s1;
    logic mosi_s2;
    logic [1:0] sync_v;
    logic armed_q;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    // Frame state
    state_e         state_q;
    state_e         state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [CW-1:0]  cnt_inc;
    logic [F-1:0]   rx_q;
    logic [F-1:0]   rx_d;
    logic [F-1:0]   tx_q;
    logic [F-1:0]   tx_d;
    logic [M-1:0]   result_q;
    logic [M-1:0]   result_now;

    // Output registers
    logic [OPW-1:0] op_q;
    logic [OPW-1:0] op_d;
    logic [M-1:0]   arga_q;
    logic [M-1:0]   arga_d;
    logic [M-1:0]   argb_q;
    logic [M-1:0]   argb_d;
    logic           valid_q;
    logic           valid_d;
    logic           err_q;
    logic           err_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_h  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_h    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            sync_v  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sclk_s1 <= i_sclk;
            sclk_s2 <= sclk_s1;
            sclk_h  <= sclk_s2;
            cs_s1   <= i_cs_n;
            cs_s2   <= cs_s1;
            cs_h    <= cs_s2;
            mosi_s1 <= i_mosi;
            mosi_s2 <= mosi_s1;
            sync_v  <= {sync_v[0], 1'b1};
            // A CS fall only counts once a genuine high has passed through the synchroniser,
            // so a window already open when reset lifts is never mistaken for a new frame.
            if (sync_v[1] && cs_s2) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_h;
    assign sclk_fall = ~sclk_s2 & sclk_h;
    assign cs_rise   = cs_s2 & ~cs_h;
    assign cs_fall   = ~cs_s2 & cs_h;

    assign result_now = i_result_valid ? i_result : result_q;
    assign cnt_inc    = cnt_q + CW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= '0;
        end else if (i_result_valid) begin
            result_q <= i_result;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            op_q    <= '0;
            arga_q  <= '0;
            argb_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            op_q    <= op_d;
            arga_q  <= arga_d;
            argb_q  <= argb_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        op_d    = op_q;
        arga_d  = arga_q;
        argb_d  = argb_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (cs_fall && armed_q) begin
                    cnt_d   = '0;
                    tx_d    = {result_now, {(F - M){1'b0}}};
                    state_d = StShift;
                end
            end

            StShift: begin
                if (cnt_q == FCNT) begin
                    op_d    = rx_q[F-1 -: OPW];
                    arga_d  = rx_q[2*M-1 -: M];
                    argb_d  = rx_q[M-1:0];
                    valid_d = 1'b1;
                    // CS may already be high if it rose together with the final bit.
                    state_d = cs_s2 ? StIdle : StWaitCs;
                end else begin
                    if (sclk_rise) begin
                        rx_d  = {rx_q[F-2:0], mosi_s2};
                        cnt_d = cnt_inc;
                    end
                    if (sclk_fall) begin
                        tx_d = {tx_q[F-2:0], 1'b0};
                    end
                    if (cs_rise && !(sclk_rise && (cnt_inc == FCNT))) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end

            StWaitCs: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign o_miso      = (state_q == StShift) ? tx_q[F-1] : 1'b0;
    assign o_op        = op_q;
    assign o_argA      = arga_q;
    assign o_argB      = argb_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_spi_exe_frame_rx.sv
// Directed bench for spi_exe_frame_rx: table of full frames plus hand-written corner sequences.
module tb_spi_exe_frame_rx;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_sclk = 1'b0;
    logic       i_cs_n = 1'b1;
    logic       i_mosi = 1'b0;
    logic       o_miso;
    logic [7:0] o_op;
    logic [3:0] o_argA;
    logic [3:0] o_argB;
    logic       o_valid;
    logic [3:0] i_result = 4'h0;
    logic       i_result_valid = 1'b0;
    logic       o_frame_err;

    int n_cmp = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    spi_exe_frame_rx #(.M(4), .OPW(8)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_sclk         (i_sclk),
        .i_cs_n         (i_cs_n),
        .i_mosi         (i_mosi),
        .o_miso         (o_miso),
        .o_op           (o_op),
        .o_argA         (o_argA),
        .o_argB         (o_argB),
        .o_valid        (o_valid),
        .i_result       (i_result),
        .i_result_valid (i_result_valid),
        .o_frame_err    (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    // Counts cycles the strobes are high; a one-cycle pulse adds exactly 1.
    always @(negedge i_clk) begin
        if (o_valid) valid_cnt <= valid_cnt + 1;
        if (o_frame_err) err_cnt <= err_cnt + 1;
    end

    typedef struct {
        logic       load;
        logic [3:0] result;
        logic [7:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [15:0] exp_miso;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic load_result(input logic [3:0] v);
        @(posedge i_clk);
        #1;
        i_result = v;
        i_result_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_result_valid = 1'b0;
    endtask

    // Bits taken MSB first from bits[19]; MISO sampled just before each SCLK rise.
    task automatic shift_bits(input logic [19:0] bits, input int n, output logic [19:0] mi);
        mi = '0;
        for (int i = 0; i < n; i++) begin
            i_mosi = bits[19-i];
            cycles(8);
            mi[19-i] = o_miso;
            i_sclk = 1'b1;
            cycles(8);
            i_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [19:0] bits, input int n, output logic [19:0] mi);
        i_cs_n = 1'b0;
        cycles(8);
        shift_bits(bits, n, mi);
        cycles(8);
        i_cs_n = 1'b1;
        cycles(12);
    endtask

    initial begin
        logic [19:0] mi;
        int v0;
        int e0;
        logic [7:0] sop;
        logic [3:0] sa;
        logic [3:0] sb;

        vecs[0] = '{1'b0, 4'h0, 8'h01, 4'hB, 4'h6, 16'h0000};
        vecs[1] = '{1'b1, 4'h5, 8'h3C, 4'h2, 4'hF, 16'h5000};
        vecs[2] = '{1'b0, 4'h0, 8'hA5, 4'h0, 4'h9, 16'h5000};
        vecs[3] = '{1'b1, 4'hF, 8'hFF, 4'hF, 4'hF, 16'hF000};
        vecs[4] = '{1'b1, 4'h0, 8'h00, 4'h0, 4'h0, 16'h0000};

        #23;
        check("reset_op", 32'(o_op), 32'h0);
        check("reset_argA", 32'(o_argA), 32'h0);
        check("reset_argB", 32'(o_argB), 32'h0);
        check("reset_valid", 32'(o_valid), 32'h0);
        check("reset_err", 32'(o_frame_err), 32'h0);
        check("reset_miso", 32'(o_miso), 32'h0);
        i_rst_n = 1'b1;
        cycles(6);

        for (int k = 0; k < 5; k++) begin
            if (vecs[k].load) load_result(vecs[k].result);
            v0 = valid_cnt;
            e0 = err_cnt;
            frame({vecs[k].op, vecs[k].a, vecs[k].b, 4'h0}, 16, mi);
            check($sformatf("vec%0d_op", k), 32'(o_op), 32'(vecs[k].op));
            check($sformatf("vec%0d_argA", k), 32'(o_argA), 32'(vecs[k].a));
            check($sformatf("vec%0d_argB", k), 32'(o_argB), 32'(vecs[k].b));
            check($sformatf("vec%0d_valid", k), 32'(valid_cnt - v0), 32'd1);
            check($sformatf("vec%0d_err", k), 32'(err_cnt - e0), 32'd0);
            check($sformatf("vec%0d_miso", k), 32'(mi[19:4]), 32'(vecs[k].exp_miso));
        end

        // Load a known pattern, then abort a frame after 10 SCLKs
        frame({20'hC7_2_9_0}, 16, mi);
        sop = o_op;
        sa = o_argA;
        sb = o_argB;
        v0 = valid_cnt;
        e0 = err_cnt;
        frame({20'h3D_E_1_0}, 10, mi);
        check("abort_err", 32'(err_cnt - e0), 32'd1);
        check("abort_valid", 32'(valid_cnt - v0), 32'd0);
        check("abort_op", 32'(o_op), 32'(sop));
        check("abort_argA", 32'(o_argA), 32'(sa));
        check("abort_argB", 32'(o_argB), 32'(sb));
        v0 = valid_cnt;
        frame({20'h12_3_4_0}, 16, mi);
        check("after_abort_op", 32'(o_op), 32'h12);
        check("after_abort_argA", 32'(o_argA), 32'h3);
        check("after_abort_argB", 32'(o_argB), 32'h4);
        check("after_abort_valid", 32'(valid_cnt - v0), 32'd1);

        // 20 SCLKs in one window
        load_result(4'h9);
        v0 = valid_cnt;
        e0 = err_cnt;
        frame({20'h7E_C_3_F}, 20, mi);
        check("long_valid", 32'(valid_cnt - v0), 32'd1);
        check("long_err", 32'(err_cnt - e0), 32'd0);
        check("long_op", 32'(o_op), 32'h7E);
        check("long_argA", 32'(o_argA), 32'hC);
        check("long_argB", 32'(o_argB), 32'h3);
        check("long_miso_head", 32'(mi[19:16]), 32'h9);
        check("long_miso_tail", 32'(mi[3:0]), 32'h0);

        // Result written in the same cycle the CS fall is detected
        load_result(4'h3);
        @(posedge i_clk);
        #1;
        i_cs_n = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_result = 4'hA;
        i_result_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_result_valid = 1'b0;
        cycles(6);
        v0 = valid_cnt;
        shift_bits({20'h66_1_8_0}, 16, mi);
        cycles(8);
        i_cs_n = 1'b1;
        cycles(12);
        check("bypass_miso", 32'(mi[19:16]), 32'hA);
        check("bypass_valid", 32'(valid_cnt - v0), 32'd1);
        check("bypass_op", 32'(o_op), 32'h66);

        // Reset mid-frame with CS held low
        v0 = valid_cnt;
        e0 = err_cnt;
        i_cs_n = 1'b0;
        cycles(8);
        shift_bits({20'hB4_D_2_0}, 8, mi);
        i_rst_n = 1'b0;
        #1;
        check("midrst_op", 32'(o_op), 32'h0);
        check("midrst_argA", 32'(o_argA), 32'h0);
        check("midrst_argB", 32'(o_argB), 32'h0);
        check("midrst_miso", 32'(o_miso), 32'h0);
        check("midrst_valid", 32'(o_valid), 32'h0);
        #20;
        i_rst_n = 1'b1;
        cycles(4);
        shift_bits({20'hD2_0_0_0}, 8, mi);
        cycles(12);
        check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
        i_cs_n = 1'b1;
        cycles(12);
        v0 = valid_cnt;
        frame({20'h5A_C_3_0}, 16, mi);
        check("postrst_op", 32'(o_op), 32'h5A);
        check("postrst_argA", 32'(o_argA), 32'hC);
        check("postrst_argB", 32'(o_argB), 32'h3);
        check("postrst_valid", 32'(valid_cnt - v0), 32'd1);
        check("postrst_miso", 32'(mi[19:4]), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
